// File: rtl/matmul_scheduler_pkg.sv
// rtl/matmul_scheduler_pkg.sv - shared state encoding and width helpers for the matmul scheduler
package matmul_scheduler_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        WAIT   = 3'd2,
        WRITE  = 3'd3,
        FINISH = 3'd4
    } state_t;

    localparam int DEF_SIZE     = 4;
    localparam int DEF_TO_SLACK = 8;

    // Dimensions carry one extra bit so that SIZE itself (and SIZE+1..) is representable.
    function automatic int dim_w(input int size);
        return $clog2(size) + 1;
    endfunction

    function automatic int sel_w(input int size);
        return $clog2(size);
    endfunction

    function automatic int addr_w(input int size);
        return $clog2(size * size);
    endfunction

    // Wide enough to hold the largest watchdog limit, 3*SIZE + slack.
    function automatic int wd_w(input int size, input int slack);
        return $clog2(3 * size + slack + 1);
    endfunction

    function automatic logic dim_ok(input int d, input int size);
        return (d >= 1) && (d <= size);
    endfunction

    localparam int DEF_DIM_W  = dim_w(DEF_SIZE);
    localparam int DEF_SEL_W  = sel_w(DEF_SIZE);
    localparam int DEF_ADDR_W = addr_w(DEF_SIZE);

endpackage

// File: rtl/matmul_scheduler_wd_timer.sv
// rtl/matmul_scheduler_wd_timer.sv - watchdog counter for one outstanding dot product
// Ports: clk, reset (sync, active-high); load clears the count; count advances it by one;
// limit is the cycle budget; expired is high in the cycle whose increment reaches limit.
module wd_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         count,
    input  logic [W-1:0] limit,
    output logic         expired
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || load) begin
            cnt <= '0;
        end else if (count) begin
            cnt <= cnt + W'(1);
        end
    end

    // Combinational so the FSM can leave WAIT in the same cycle the budget is used up.
    assign expired = count && ((cnt + W'(1)) >= limit);

endmodule

// File: rtl/matmul_scheduler.sv
// rtl/matmul_scheduler.sv - walks a rows x cols result matrix, issuing one dot product per element
// Ports: clk, reset (sync, active-high); cmd_valid/cmd_ready with cmd_rows/cmd_cols/cmd_k command;
// abort cancels the active command; dp_start/dp_len/dp_row/dp_col drive the dot-product controller,
// dp_done returns from it; wr_en/wr_addr write each result; busy, done (pulse), err (pulse) status.
module matmul_scheduler
    import matmul_scheduler_pkg::*;
#(
    parameter int SIZE     = DEF_SIZE,
    parameter int TO_SLACK = DEF_TO_SLACK,
    localparam int DIM_W   = dim_w(SIZE),
    localparam int SEL_W   = sel_w(SIZE),
    localparam int ADDR_W  = addr_w(SIZE),
    localparam int WD_W    = wd_w(SIZE, TO_SLACK)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DIM_W-1:0]  cmd_rows,
    input  logic [DIM_W-1:0]  cmd_cols,
    input  logic [DIM_W-1:0]  cmd_k,
    input  logic              abort,
    output logic              dp_start,
    output logic [DIM_W-1:0]  dp_len,
    output logic [SEL_W-1:0]  dp_row,
    output logic [SEL_W-1:0]  dp_col,
    input  logic              dp_done,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_t           state, state_n;
    logic [DIM_W-1:0] rows_q, cols_q, k_q, rows_n, cols_n, k_n;
    logic [SEL_W-1:0] row_q, col_q, row_n, col_n;
    logic             err_n;
    logic             wd_load, wd_count, wd_expired;
    logic [WD_W-1:0]  wd_limit;
    logic             cmd_legal, last_col, last_row;

    assign cmd_legal = dim_ok(int'(cmd_rows), SIZE) && dim_ok(int'(cmd_cols), SIZE)
                    && dim_ok(int'(cmd_k), SIZE);
    assign last_col  = ({1'b0, col_q} == cols_q - DIM_W'(1));
    assign last_row  = ({1'b0, row_q} == rows_q - DIM_W'(1));
    assign wd_limit  = WD_W'(3 * int'(k_q) + TO_SLACK);

    wd_timer #(.W(WD_W)) u_wd (
        .clk     (clk),
        .reset   (reset),
        .load    (wd_load),
        .count   (wd_count),
        .limit   (wd_limit),
        .expired (wd_expired)
    );

    always_comb begin
        state_n  = state;
        rows_n   = rows_q;
        cols_n   = cols_q;
        k_n      = k_q;
        row_n    = row_q;
        col_n    = col_q;
        err_n    = 1'b0;
        wd_load  = 1'b0;
        wd_count = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_legal) begin
                        rows_n  = cmd_rows;
                        cols_n  = cmd_cols;
                        k_n     = cmd_k;
                        row_n   = '0;
                        col_n   = '0;
                        state_n = ISSUE;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            ISSUE: begin
                wd_load = 1'b1;
                state_n = WAIT;
            end
            WAIT: begin
                wd_count = 1'b1;
                // A completion arriving on the last budgeted cycle still counts as on time.
                if (dp_done) begin
                    state_n = WRITE;
                end else if (wd_expired) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end
            end
            WRITE: begin
                if (last_col) begin
                    col_n = '0;
                    if (last_row) begin
                        state_n = FINISH;
                    end else begin
                        row_n   = row_q + SEL_W'(1);
                        state_n = ISSUE;
                    end
                end else begin
                    col_n   = col_q + SEL_W'(1);
                    state_n = ISSUE;
                end
            end
            FINISH: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // Abort outranks completion and timeout; it never raises err.
        if (abort && (state != IDLE)) begin
            state_n = IDLE;
            err_n   = 1'b0;
        end
    end

    // Every output is registered off the next state so pulses line up with the state they mark.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rows_q    <= '0;
            cols_q    <= '0;
            k_q       <= '0;
            row_q     <= '0;
            col_q     <= '0;
            cmd_ready <= 1'b1;
            dp_start  <= 1'b0;
            dp_len    <= '0;
            dp_row    <= '0;
            dp_col    <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            rows_q    <= rows_n;
            cols_q    <= cols_n;
            k_q       <= k_n;
            row_q     <= row_n;
            col_q     <= col_n;
            cmd_ready <= (state_n == IDLE);
            dp_start  <= (state_n == ISSUE);
            if (state_n == ISSUE) begin
                dp_len <= k_n;
                dp_row <= row_n;
                dp_col <= col_n;
            end
            wr_en <= (state_n == WRITE);
            if (state_n == WRITE) begin
                wr_addr <= ADDR_W'(int'(row_q) * SIZE + int'(col_q));
            end
            busy <= (state_n != IDLE);
            done <= (state_n == FINISH);
            err  <= err_n;
        end
    end

endmodule
